// File: rtl/mux_9bit_4to1_if.sv
// Operand/result bundle for the 9-bit ALU operand multiplexer.
// The master drives the operands and the select. The slave (the mux) returns the result.
interface mux_9bit_4to1_if #(
  parameter int WIDTH = 9
);
  logic             in_valid;
  logic [1:0]       select;
  logic [WIDTH-1:0] inputA;
  logic [WIDTH-1:0] inputB;
  logic [WIDTH-1:0] inputC;
  logic [WIDTH-1:0] inputD;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  modport master (
    output in_valid, select, inputA, inputB, inputC, inputD,
    input  out, out_valid
  );

  modport slave (
    input  in_valid, select, inputA, inputB, inputC, inputD,
    output out, out_valid
  );
endinterface

// File: rtl/mux_9bit_4to1.sv
// Selects one of four operand buses for the 9-bit ALU datapath.
// REGISTER_OUT=1 gives a registered result with 1-cycle latency and a valid flag.
// REGISTER_OUT=0 gives a purely combinational bypass, in which case clk and rst_n are unused.
module mux_9bit_4to1 #(
  parameter int WIDTH        = 9,
  parameter bit REGISTER_OUT = 1
) (
  input logic               clk,
  input logic               rst_n,
  mux_9bit_4to1_if.slave    bus
);

  // Stage p0: combinational one-of-four selection.
  logic [WIDTH-1:0] sel_data_p0;
  logic             vld_p0;

  assign vld_p0 = bus.in_valid;

  // Selection is bit-exact. An unknown select drives X in simulation and is a don't-care in synthesis.
  always_comb begin
    sel_data_p0 = '0;
    case (bus.select)
      2'b00:   sel_data_p0 = bus.inputA;
      2'b01:   sel_data_p0 = bus.inputB;
      2'b10:   sel_data_p0 = bus.inputC;
      2'b11:   sel_data_p0 = bus.inputD;
      default: sel_data_p0 = 'x;
    endcase
  end

  generate
    if (REGISTER_OUT) begin : g_reg
      // Stage p1: registered result.
      logic [WIDTH-1:0] out_p1;
      logic             vld_p1;

      // Capture on valid and hold otherwise. Reset clears the result so that no in-flight value survives.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_p1 <= '0;
          vld_p1 <= 1'b0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) begin
            out_p1 <= sel_data_p0;
          end
        end
      end

      assign bus.out       = out_p1;
      assign bus.out_valid = vld_p1;
    end else begin : g_comb
      assign bus.out       = sel_data_p0;
      assign bus.out_valid = vld_p0;
    end
  endgenerate

endmodule

// File: tb/tb_mux_9bit_4to1.sv
// Directed bench for mux_9bit_4to1. It covers the registered variant and the combinational bypass variant.
module tb_mux_9bit_4to1;
  localparam int WIDTH = 9;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  mux_9bit_4to1_if #(.WIDTH(WIDTH)) reg_if ();
  mux_9bit_4to1_if #(.WIDTH(WIDTH)) comb_if ();

  mux_9bit_4to1 #(.WIDTH(WIDTH), .REGISTER_OUT(1'b1)) dut_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (reg_if)
  );

  mux_9bit_4to1 #(.WIDTH(WIDTH), .REGISTER_OUT(1'b0)) dut_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (comb_if)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [1:0] sel,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
    reg_if.in_valid  = v;   comb_if.in_valid = v;
    reg_if.select    = sel; comb_if.select   = sel;
    reg_if.inputA    = a;   comb_if.inputA   = a;
    reg_if.inputB    = b;   comb_if.inputB   = b;
    reg_if.inputC    = c;   comb_if.inputC   = c;
    reg_if.inputD    = d;   comb_if.inputD   = d;
  endtask

  logic [WIDTH-1:0] bvals [4];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive(1'b1, 2'b00, 9'd5, 9'd6, 9'd7, 9'd8);

    // Reset held: activity on the inputs must not reach the registered output.
    repeat (2) @(negedge clk);
    check("rst_out_0", reg_if.out, 9'd0);
    check("rst_vld_0", {8'd0, reg_if.out_valid}, 9'd0);
    drive(1'b1, 2'b11, 9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);
    @(negedge clk);
    check("rst_out_1", reg_if.out, 9'd0);
    check("rst_vld_1", {8'd0, reg_if.out_valid}, 9'd0);

    // Release, then the first capture.
    rst_n = 1'b1;
    drive(1'b1, 2'b00, 9'd1, 9'd2, 9'd3, 9'd4);
    @(negedge clk);
    check("first_out", reg_if.out, 9'd1);
    check("first_vld", {8'd0, reg_if.out_valid}, 9'd1);

    // Select sweep, one cycle each, back to back with 1-cycle latency.
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 2'(s), 9'd1, 9'd2, 9'd3, 9'd4);
      #1;
      check($sformatf("comb_sweep_%0d", s), comb_if.out, 9'(s + 1));
      @(negedge clk);
      check($sformatf("sweep_out_%0d", s), reg_if.out, 9'(s + 1));
      check($sformatf("sweep_vld_%0d", s), {8'd0, reg_if.out_valid}, 9'd1);
    end

    // Hold: the last capture was select=11, D=4.
    drive(1'b0, 2'b00, 9'd1, 9'd2, 9'd3, 9'h1FF);
    #1;
    check("comb_vld_low", {8'd0, comb_if.out_valid}, 9'd0);
    check("comb_noval_out", comb_if.out, 9'd1);
    @(negedge clk);
    check("hold_out_0", reg_if.out, 9'd4);
    check("hold_vld_0", {8'd0, reg_if.out_valid}, 9'd0);
    @(negedge clk);
    check("hold_out_1", reg_if.out, 9'd4);

    // Input changes between edges do not reach out before the next edge.
    drive(1'b1, 2'b10, 9'd1, 9'd2, 9'd3, 9'd4);
    @(negedge clk);
    check("pre_rst_out", reg_if.out, 9'd3);
    drive(1'b1, 2'b01, 9'd1, 9'd2, 9'd3, 9'd4);
    #1;
    check("between_edges", reg_if.out, 9'd3);

    // Asynchronous reset between edges, with no clock edge involved.
    rst_n = 1'b0;
    #0.5;
    check("async_rst_out", reg_if.out, 9'd0);
    check("async_rst_vld", {8'd0, reg_if.out_valid}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'b11, 9'd1, 9'd2, 9'd3, 9'd4);
    @(negedge clk);
    check("post_rst_idle", reg_if.out, 9'd0);
    check("post_rst_vld", {8'd0, reg_if.out_valid}, 9'd0);

    // Boundary data through all selects. The registered and combinational variants must show the same values.
    bvals[0] = 9'h1FF; bvals[1] = 9'h000; bvals[2] = 9'h155; bvals[3] = 9'h0AA;
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 2'(s), 9'h1FF, 9'h000, 9'h155, 9'h0AA);
      #1;
      check($sformatf("comb_bnd_%0d", s), comb_if.out, bvals[s]);
      check($sformatf("comb_bnd_vld_%0d", s), {8'd0, comb_if.out_valid}, 9'd1);
      @(negedge clk);
      check($sformatf("bnd_out_%0d", s), reg_if.out, bvals[s]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
